dec_2to4: RTL and testbench

- Registered 2-to-4 one-hot decoder with enable and output-valid flag.
- Converts a 2-bit select `s` into a 4-bit one-hot word `I`. Used as a small address/strobe generator in the control path.
- One clock, asynchronous active-high reset. All outputs are registered, so downstream logic sees glitch-free strobes.

---
 rtl/dec_2to4.sv | 72 +++++++
 tb/tb_dec_2to4.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dec_2to4.sv
// Registered 2-to-4 one-hot decoder with enable, output-valid flag and optional
// per-output hit counters (enabled by defining DEC_HIT_CNT_EN).
module dec_2to4 #(
    parameter  int SEL_W      = 2,
    parameter  int ACTIVE_LOW = 0,
    parameter  int CNT_W      = 8,
    localparam int OUT_W      = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] s,
    output logic [OUT_W-1:0] I,
    output logic             valid
`ifdef DEC_HIT_CNT_EN
    ,
    output logic [OUT_W*CNT_W-1:0] hit_cnt
`endif
);

    localparam logic [OUT_W-1:0] IDLE = {OUT_W{ACTIVE_LOW != 0}};

    logic [OUT_W-1:0] w_onehot;
    logic [OUT_W-1:0] w_next;
    logic [OUT_W-1:0] r_dec;
    logic             r_valid;

    always_comb begin
        w_onehot    = '0;
        w_onehot[s] = 1'b1;
        if (!en)
            w_next = IDLE;
        else if (ACTIVE_LOW != 0)
            w_next = ~w_onehot;
        else
            w_next = w_onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec   <= IDLE;
            r_valid <= 1'b0;
        end else begin
            r_dec   <= w_next;
            r_valid <= en;
        end
    end

    assign I     = r_dec;
    assign valid = r_valid;

`ifdef DEC_HIT_CNT_EN
    logic [CNT_W-1:0] r_hit [OUT_W];

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUT_W; k++)
                r_hit[k] <= '0;
        end else if (en) begin
            for (int k = 0; k < OUT_W; k++)
                if (s == SEL_W'(k) && r_hit[k] != {CNT_W{1'b1}})
                    r_hit[k] <= r_hit[k] + 1'b1;
        end
    end

    for (genvar g = 0; g < OUT_W; g++) begin : g_hit
        assign hit_cnt[g*CNT_W +: CNT_W] = r_hit[g];
    end
`endif

endmodule

// File: tb/tb_dec_2to4.sv
// Directed bench for dec_2to4: default build plus an ACTIVE_LOW=1 instance
// sharing the same stimulus; hit counters are exercised when DEC_HIT_CNT_EN is set.
module tb_dec_2to4;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic [1:0] s;
    logic [3:0] w_i_hi;
    logic [3:0] w_i_lo;
    logic       w_v_hi;
    logic       w_v_lo;
`ifdef DEC_HIT_CNT_EN
    logic [31:0] w_hit_hi;
    logic [31:0] w_hit_lo;
`endif

    int checks = 0;
    int errors = 0;

    dec_2to4 #(.SEL_W(2), .ACTIVE_LOW(0), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .s(s), .I(w_i_hi), .valid(w_v_hi)
`ifdef DEC_HIT_CNT_EN
        , .hit_cnt(w_hit_hi)
`endif
    );

    dec_2to4 #(.SEL_W(2), .ACTIVE_LOW(1), .CNT_W(8)) u_dut_al (
        .clk(clk), .rst(rst), .en(en), .s(s), .I(w_i_lo), .valid(w_v_lo)
`ifdef DEC_HIT_CNT_EN
        , .hit_cnt(w_hit_lo)
`endif
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; clk_run = 1'b0; rst = 1'b0; en = 1'b0; s = 2'd0;

        // Reset with the clock idle.
        #3 rst = 1'b1;
        #1;
        check("rst_I", 32'(w_i_hi), 32'h0);
        check("rst_valid", 32'(w_v_hi), 32'h0);
        check("rst_I_al", 32'(w_i_lo), 32'hF);
        check("rst_valid_al", 32'(w_v_lo), 32'h0);
        #2 rst = 1'b0;
        #2;
        check("rel_I", 32'(w_i_hi), 32'h0);
        check("rel_valid", 32'(w_v_hi), 32'h0);

        clk_run = 1'b1;

        // Sweep s on consecutive edges.
        en = 1'b1; s = 2'd0;
        edge_step();
        check("sw0_I", 32'(w_i_hi), 32'h1);
        check("sw0_valid", 32'(w_v_hi), 32'h1);
        s = 2'd1;
        edge_step();
        check("sw1_I", 32'(w_i_hi), 32'h2);
        check("sw1_valid", 32'(w_v_hi), 32'h1);
        s = 2'd2;
        edge_step();
        check("sw2_I", 32'(w_i_hi), 32'h4);
        check("sw2_valid", 32'(w_v_hi), 32'h1);
        check("sw2_I_al", 32'(w_i_lo), 32'hB);
        s = 2'd3;
        edge_step();
        check("sw3_I", 32'(w_i_hi), 32'h8);
        check("sw3_valid", 32'(w_v_hi), 32'h1);
        check("sw3_I_al", 32'(w_i_lo), 32'h7);
        check("sw3_valid_al", 32'(w_v_lo), 32'h1);

        // Enabled decode followed by a disabled edge.
        s = 2'd2;
        edge_step();
        check("en_I", 32'(w_i_hi), 32'h4);
        check("en_valid", 32'(w_v_hi), 32'h1);
        en = 1'b0;
        edge_step();
        check("dis_I", 32'(w_i_hi), 32'h0);
        check("dis_valid", 32'(w_v_hi), 32'h0);
        check("dis_I_al", 32'(w_i_lo), 32'hF);
        check("dis_valid_al", 32'(w_v_lo), 32'h0);

        // Mid-stream reset pulse between edges.
        en = 1'b1; s = 2'd3;
        edge_step();
        check("pre_rst_I", 32'(w_i_hi), 32'h8);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_I", 32'(w_i_hi), 32'h0);
        check("mid_rst_valid", 32'(w_v_hi), 32'h0);
        check("mid_rst_I_al", 32'(w_i_lo), 32'hF);
        #1 rst = 1'b0; s = 2'd1;
        edge_step();
        check("post_rst_I", 32'(w_i_hi), 32'h2);
        check("post_rst_valid", 32'(w_v_hi), 32'h1);
        check("post_rst_I_al", 32'(w_i_lo), 32'hD);

`ifdef DEC_HIT_CNT_EN
        // Clear counters, then 300 hits on line 0 and 3 on line 1.
        en = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        check("hit_clr0", 32'(w_hit_hi), 32'h0);
        en = 1'b1; s = 2'd0;
        for (int n = 0; n < 300; n++) edge_step();
        s = 2'd1;
        for (int n = 0; n < 3; n++) edge_step();
        en = 1'b0;
        edge_step();
        check("hit_c0", 32'(w_hit_hi[7:0]), 32'd255);
        check("hit_c1", 32'(w_hit_hi[15:8]), 32'd3);
        check("hit_c2", 32'(w_hit_hi[23:16]), 32'd0);
        check("hit_c3", 32'(w_hit_hi[31:24]), 32'd0);
        check("hit_c0_al", 32'(w_hit_lo[7:0]), 32'd255);
        #1 rst = 1'b1;
        #1;
        check("hit_clr", 32'(w_hit_hi), 32'h0);
        rst = 1'b0;
`endif

        clk_run = 1'b0;
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
